// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for a small combinational gate: walks every input vector,
// waits a settle time, and checks the gate output against a truth table.
module gate_bist_ctrl #(
  parameter int unsigned NUM_INPUTS    = 2,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [(2**NUM_INPUTS)-1:0] TRUTH_TABLE = 4'b0111
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  dut_out,
  output logic [NUM_INPUTS-1:0] dut_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [NUM_INPUTS:0]   err_count,
  output logic                  fail_pulse,
  output logic [NUM_INPUTS-1:0] first_fail_vec,
  output logic                  fail_seen
);

  localparam int unsigned CNT_W = 4;
  localparam logic [NUM_INPUTS-1:0] LAST_VEC    = {NUM_INPUTS{1'b1}};
  localparam logic [NUM_INPUTS:0]   ERR_ONE     = 1;
  localparam logic [CNT_W-1:0]      SETTLE_LOAD =
    (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     settle_cnt;
  logic                 mismatch;
  logic [NUM_INPUTS:0]  err_next;

  // dut_in doubles as the vector counter while a run is in progress
  assign mismatch = (dut_out != TRUTH_TABLE[dut_in]);
  assign err_next = mismatch ? (err_count + ERR_ONE) : err_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      dut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_pulse     <= 1'b0;
      first_fail_vec <= '0;
      fail_seen      <= 1'b0;
    end else begin
      fail_pulse <= 1'b0;
      if (abort) begin
        // abort beats start; error bookkeeping is kept for inspection
        state      <= IDLE;
        settle_cnt <= '0;
        dut_in     <= '0;
        busy       <= 1'b0;
        done       <= 1'b0;
        pass       <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state          <= APPLY;
              dut_in         <= '0;
              err_count      <= '0;
              fail_seen      <= 1'b0;
              first_fail_vec <= '0;
              done           <= 1'b0;
              pass           <= 1'b0;
              busy           <= 1'b1;
            end
          end
          APPLY: begin
            if (SETTLE_CYCLES == 0) begin
              state <= CHECK;
            end else begin
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end
          end
          SETTLE: begin
            if (settle_cnt == '0) begin
              state <= CHECK;
            end else begin
              settle_cnt <= settle_cnt - 1'b1;
            end
          end
          CHECK: begin
            err_count <= err_next;
            if (mismatch) begin
              fail_pulse <= 1'b1;
              if (!fail_seen) begin
                first_fail_vec <= dut_in;
                fail_seen      <= 1'b1;
              end
            end
            if (dut_in == LAST_VEC) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              state  <= APPLY;
              dut_in <= dut_in + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl: two instances (settle 1 and 0)
// driving a behavioural gate, checked against a timeline/arithmetic model.
module tb_gate_bist_ctrl;

  localparam logic [3:0] REF_TT = 4'b0111;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic       sel;
  logic [3:0] gate_tt;

  logic       a_start, a_abort, a_dut_out;
  logic [1:0] a_dut_in, a_first_fail_vec;
  logic       a_busy, a_done, a_pass, a_fail_pulse, a_fail_seen;
  logic [2:0] a_err_count;

  logic       b_start, b_abort, b_dut_out;
  logic [1:0] b_dut_in, b_first_fail_vec;
  logic       b_busy, b_done, b_pass, b_fail_pulse, b_fail_seen;
  logic [2:0] b_err_count;

  logic [1:0] m_dut_in, m_first_fail_vec;
  logic       m_busy, m_done, m_pass, m_fail_pulse, m_fail_seen;
  logic [2:0] m_err_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign a_start   = start & ~sel;
  assign a_abort   = abort & ~sel;
  assign b_start   = start & sel;
  assign b_abort   = abort & sel;
  assign a_dut_out = gate_tt[a_dut_in];
  assign b_dut_out = gate_tt[b_dut_in];

  assign m_dut_in         = sel ? b_dut_in         : a_dut_in;
  assign m_first_fail_vec = sel ? b_first_fail_vec : a_first_fail_vec;
  assign m_busy           = sel ? b_busy           : a_busy;
  assign m_done           = sel ? b_done           : a_done;
  assign m_pass           = sel ? b_pass           : a_pass;
  assign m_fail_pulse     = sel ? b_fail_pulse     : a_fail_pulse;
  assign m_fail_seen      = sel ? b_fail_seen      : a_fail_seen;
  assign m_err_count      = sel ? b_err_count      : a_err_count;

  gate_bist_ctrl #(.NUM_INPUTS(2), .SETTLE_CYCLES(1), .TRUTH_TABLE(REF_TT)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(a_start), .abort(a_abort),
    .dut_out(a_dut_out), .dut_in(a_dut_in), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_count(a_err_count), .fail_pulse(a_fail_pulse),
    .first_fail_vec(a_first_fail_vec), .fail_seen(a_fail_seen)
  );

  gate_bist_ctrl #(.NUM_INPUTS(2), .SETTLE_CYCLES(0), .TRUTH_TABLE(REF_TT)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(b_start), .abort(b_abort),
    .dut_out(b_dut_out), .dut_in(b_dut_in), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_count(b_err_count), .fail_pulse(b_fail_pulse),
    .first_fail_vec(b_first_fail_vec), .fail_seen(b_fail_seen)
  );

  // mismatches among the first n vectors of a miss mask
  function automatic int miss_below(input logic [3:0] miss, input int n);
    int c = 0;
    for (int i = 0; i < 4; i++) if (i < n && miss[i]) c++;
    return c;
  endfunction

  function automatic logic [1:0] lowest_miss(input logic [3:0] miss);
    for (int i = 3; i >= 0; i--) if (miss[i]) lowest_miss = 2'(i);
  endfunction

  task automatic check_all_zero(input string name);
    total++;
    if (m_dut_in !== 2'b0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_pass !== 1'b0 ||
        m_err_count !== 3'b0 || m_fail_pulse !== 1'b0 || m_first_fail_vec !== 2'b0 ||
        m_fail_seen !== 1'b0) begin
      bad++;
      $display("FAIL %s: got dut_in=%b busy=%b done=%b pass=%b err=%0d pulse=%b ffv=%b seen=%b, want all 0",
               name, m_dut_in, m_busy, m_done, m_pass, m_err_count, m_fail_pulse,
               m_first_fail_vec, m_fail_seen);
    end
  endtask

  // one full run on the selected instance; repulse_k re-asserts start mid-run
  task automatic run_check(input string name, input logic [3:0] tt, input int repulse_k);
    int         per = sel ? 2 : 3;
    int         len = 4 * per;
    logic [3:0] miss = tt ^ REF_TT;
    int         exp_err = miss_below(miss, 4);
    int         nchk;
    logic       exp_pulse;
    gate_tt = tt;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    total++;
    if (m_busy !== 1'b1 || m_done !== 1'b0 || m_dut_in !== 2'b00 || m_err_count !== 3'b0 ||
        m_fail_seen !== 1'b0 || m_pass !== 1'b0) begin
      bad++;
      $display("FAIL %s accept: busy=%b done=%b dut_in=%b err=%0d seen=%b pass=%b, want 1 0 00 0 0 0",
               name, m_busy, m_done, m_dut_in, m_err_count, m_fail_seen, m_pass);
    end
    for (int k = 1; k <= len + 2; k++) begin
      @(posedge clock); #1;
      start = (k == repulse_k);
      nchk = k / per;
      if (nchk > 4) nchk = 4;
      exp_pulse = (k % per == 0) && (k / per >= 1) && (k / per <= 4) && miss[(k / per) - 1];
      total++;
      if (m_fail_pulse !== exp_pulse) begin
        bad++;
        $display("FAIL %s pulse k=%0d: got %b want %b", name, k, m_fail_pulse, exp_pulse);
      end
      total++;
      if (m_err_count !== 3'(miss_below(miss, nchk))) begin
        bad++;
        $display("FAIL %s err_count k=%0d: got %0d want %0d", name, k, m_err_count,
                 miss_below(miss, nchk));
      end
      if (k < len) begin
        total++;
        if (m_busy !== 1'b1 || m_done !== 1'b0 || m_dut_in !== 2'(k / per)) begin
          bad++;
          $display("FAIL %s run k=%0d: busy=%b done=%b dut_in=%0d want 1 0 %0d",
                   name, k, m_busy, m_done, m_dut_in, k / per);
        end
      end else begin
        total++;
        if (m_busy !== 1'b0 || m_done !== 1'b1 || m_pass !== (exp_err == 0) ||
            m_fail_seen !== (exp_err != 0)) begin
          bad++;
          $display("FAIL %s done k=%0d: busy=%b done=%b pass=%b seen=%b want 0 1 %b %b",
                   name, k, m_busy, m_done, m_pass, m_fail_seen, exp_err == 0, exp_err != 0);
        end
        if (exp_err != 0) begin
          total++;
          if (m_first_fail_vec !== lowest_miss(miss)) begin
            bad++;
            $display("FAIL %s first_fail_vec: got %b want %b", name, m_first_fail_vec,
                     lowest_miss(miss));
          end
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0; gate_tt = REF_TT;
    #23;
    check_all_zero("reset_a");
    sel = 1'b1; #1;
    check_all_zero("reset_b");
    sel = 1'b0;
    #3 reset_n = 1'b1;
  endtask

  task automatic test_patterns;
    sel = 1'b0;
    run_check("nand", REF_TT, -1);
    run_check("stuck1", 4'b1111, -1);
    run_check("and", 4'b1000, -1);
    for (int i = 0; i < 4; i++) run_check("rand_a", 4'($urandom_range(0, 15)), -1);
  endtask

  task automatic test_settle0;
    sel = 1'b1;
    run_check("s0_nand", REF_TT, -1);
    run_check("s0_rerun", REF_TT, -1);
    run_check("s0_and", 4'b1000, -1);
    run_check("s0_clear", REF_TT, -1);
    for (int i = 0; i < 3; i++) run_check("rand_b", 4'($urandom_range(0, 15)), -1);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back;
    sel = 1'b0;
    run_check("repulse", REF_TT, 4);
    run_check("repulse_rand", 4'($urandom_range(0, 15)), 1 + int'($urandom_range(0, 9)));
  endtask

  task automatic test_abort;
    logic [3:0] miss = 4'b1000 ^ REF_TT;
    sel = 1'b0; gate_tt = 4'b1000;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clock); #1;
    end
    abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    total++;
    if (m_busy !== 1'b0 || m_done !== 1'b0 || m_dut_in !== 2'b00) begin
      bad++;
      $display("FAIL abort state: busy=%b done=%b dut_in=%b want 0 0 00", m_busy, m_done, m_dut_in);
    end
    total++;
    if (m_err_count !== 3'(miss_below(miss, 8 / 3)) || m_fail_seen !== 1'b1 ||
        m_first_fail_vec !== 2'b00) begin
      bad++;
      $display("FAIL abort retain: err=%0d seen=%b ffv=%b want %0d 1 00",
               m_err_count, m_fail_seen, m_first_fail_vec, miss_below(miss, 8 / 3));
    end
    start = 1'b1; abort = 1'b1;
    @(posedge clock); #1 start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (m_busy !== 1'b0 || m_dut_in !== 2'b00 || m_err_count !== 3'(miss_below(miss, 2))) begin
      bad++;
      $display("FAIL abort_wins: busy=%b dut_in=%b err=%0d want 0 00 %0d",
               m_busy, m_dut_in, m_err_count, miss_below(miss, 2));
    end
  endtask

  task automatic test_reset_mid;
    sel = 1'b0; gate_tt = 4'b1000;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); #1;
    end
    total++;
    if (m_busy !== 1'b1 || m_dut_in !== 2'b01 || m_err_count !== 3'd1) begin
      bad++;
      $display("FAIL pre_reset: busy=%b dut_in=%b err=%0d want 1 01 1", m_busy, m_dut_in, m_err_count);
    end
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    #2 reset_n = 1'b1;
    run_check("post_reset", REF_TT, -1);
  endtask

  initial begin
    test_reset;
    test_patterns;
    test_settle0;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_bist_ctrl.md
Name: gate_bist_ctrl

Overview:
Built-in self-test sequencer for a small combinational gate under test (DUT), e.g. the 2-input nand_gate.
- Walks all 2^NUM_INPUTS input vectors in ascending order and drives each onto the DUT inputs.
- Waits a programmable settle time, then samples the DUT output and compares it against a parameterised truth table.
- Counts mismatches and records the first failing vector, replacing clock-driven software benches with a hardware checker usable on the board.

Parameters:
NUM_INPUTS, 2, number of DUT input bits; 1..4 supported.
SETTLE_CYCLES, 1, cycles between vector drive and output compare; 0..15.
TRUTH_TABLE, 4'b0111, expected output; bit i = expected DUT output for input vector i; width 2^NUM_INPUTS. Default is NAND.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  begin a test run; sampled only in IDLE or DONE.
abort  input  1  synchronous; terminate the run and return to IDLE.
dut_out  input  1  DUT output under test.
dut_in  output  NUM_INPUTS  registered vector driven to the DUT.
busy  output  1  high in APPLY/SETTLE/CHECK.
done  output  1  high in DONE, held until the next start, abort or reset.
pass  output  1  valid when done=1; 1 iff err_count==0.
err_count  output  NUM_INPUTS+1  number of mismatching vectors; saturation impossible (max 2^NUM_INPUTS).
fail_pulse  output  1  one-cycle pulse on the cycle after a mismatching CHECK.
first_fail_vec  output  NUM_INPUTS  first mismatching vector of the run; valid when fail_seen=1.
fail_seen  output  1  sticky; at least one mismatch this run.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; dut_in=0, busy=0, done=0, pass=0, err_count=0, fail_pulse=0, first_fail_vec=0, fail_seen=0, settle counter=0. Reset asserted mid-run aborts immediately. No partial results are retained.
- States: IDLE, APPLY, SETTLE, CHECK, DONE. All outputs are registered.
- IDLE/DONE with start=1: next state APPLY.
  - vec=0, dut_in=0, err_count=0, fail_seen=0, first_fail_vec=0, done=0, pass=0, busy=1.
- APPLY: lasts 1 cycle.
  - Next state is SETTLE with counter loaded to SETTLE_CYCLES-1.
  - If SETTLE_CYCLES=0, next state is CHECK.
- SETTLE: counter decrements each cycle; leave for CHECK when counter==0. Lasts exactly SETTLE_CYCLES cycles.
- CHECK: lasts 1 cycle. At its closing edge:
  - Compare dut_out with TRUTH_TABLE[vec].
  - On mismatch: err_count+1; fail_pulse=1 for the following cycle.
  - If fail_seen=0 on a mismatch: first_fail_vec=vec, fail_seen=1.
  - X/Z on dut_out counts as a mismatch in simulation (use !==-style compare semantics in the bench model only; RTL compares as-is).
  - If vec==2^NUM_INPUTS-1: go to DONE (busy=0, done=1, pass=(final err_count==0)).
  - Otherwise: vec+1, dut_in updated on the same edge, go to APPLY.
- Per-vector cost: SETTLE_CYCLES+2 cycles. done rises 2^NUM_INPUTS*(SETTLE_CYCLES+2) rising edges after the edge that accepted start. Defaults: 12 edges.
- Vector order: strictly ascending 0..2^N-1, no wrap. The vector counter never exceeds the max.
- start while busy: ignored, no restart.
- start in DONE: restarts the run, clearing all results on the accepting edge.
- abort (any state except IDLE): next state IDLE; busy=0, done=0; err_count/fail_seen/first_fail_vec hold their current values; dut_in returns to 0.
- abort and start both high on the same edge: abort wins.
- In IDLE and DONE, dut_in holds 0 and last-run results respectively.

Test Plan:
1. Defaults, DUT=correct NAND, pulse start 1 cycle → dut_in sequence 00,01,10,11, each held 3 cycles; done=1 at edge 12; pass=1, err_count=0, fail_seen=0, no fail_pulse.
2. Defaults, DUT output stuck at 1 → err_count=1, first_fail_vec=2'b11, fail_pulse exactly once (after vector 3 CHECK), pass=0.
3. Defaults, DUT=AND gate → err_count=4, first_fail_vec=2'b00, four fail_pulses, pass=0.
4. SETTLE_CYCLES=0, correct NAND → each vector held 2 cycles, done at edge 8, pass=1. Second start from DONE → results clear on the accepting edge, identical rerun.
5. start re-pulsed during vector 1 → ignored, run completes at edge 12. Separate run: abort during vector 2 → IDLE next cycle, done=0, busy=0, dut_in=0, err_count retained.
6. reset_n driven low asynchronously mid-SETTLE (between clock edges) → all outputs 0 immediately without a clock edge. After release, start → full run from vector 0.
